product_bcd_converter: RTL and testbench
========================================

# product_bcd_converter

Sequential binary-to-BCD converter for the product word of the Booth multiplier. It sits directly downstream of the multiplier control FSM. It captures the product when the multiplier raises its level `ready`, then converts sign and magnitude to packed BCD digits with a double-dabble shift/add-3 state machine. The held result feeds the display driver.

## Interface
- `WIDTH`, 16, width of the incoming product word.
- `DIGITS`, 5, number of BCD output digits; must satisfy 10^DIGITS > 2^WIDTH.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `valid`  in  1  level: product is stable; tied to the multiplier `ready`.
- `product`  in  WIDTH  product word; two's complement or unsigned, see Configuration.
- `busy`  out  1  high from the LOAD state through the last SHIFT state.
- `done`  out  1  one-cycle pulse when `bcd`/`sign` update.
- `sign`  out  1  1 = negative result.
- `bcd`  out  4*DIGITS  packed BCD magnitude; digit 0 is bits [3:0] (ones).

## Operation
- States: IDLE, LOAD, ADJUST, SHIFT, DONE, HOLD.
- IDLE:
  - Stays in IDLE while `valid`=0.
  - On the edge where `valid`=1: registers `product` into the capture register and goes to LOAD.
- LOAD:
  - Computes the sign and magnitude: magnitude = -product when signed and the MSB is 1; otherwise magnitude = product.
  - The magnitude is WIDTH-bit unsigned, so 2^(WIDTH-1) is representable.
  - Clears the BCD scratch register and the shift counter, then goes to ADJUST.
- ADJUST: adds 3 to every scratch digit that is ≥5 (all digits in parallel), then goes to SHIFT.
- SHIFT:
  - Shifts {scratch, magnitude} left by 1 and increments the counter.
  - Goes to DONE when the counter reaches WIDTH (after the WIDTH-th shift); otherwise goes back to ADJUST.
- DONE:
  - `bcd` and `sign` load from the scratch register on the entry edge.
  - `done`=1 for this cycle only, then goes to HOLD.
- HOLD: stays in HOLD while `valid`=1 and goes to IDLE when `valid`=0. A single multiplier `ready` assertion therefore yields exactly one conversion.
- `bcd`/`sign` hold the last result until the next DONE. They are never cleared by a new conversion starting.
- Changes on `product` or `valid` after capture are ignored until HOLD/IDLE.
- Shift counter width: $clog2(WIDTH+1).
- A scratch digit never exceeds 9 after SHIFT.

## Timing
- Reset (asynchronous assert, any state):
  - State goes to IDLE.
  - `busy`=0, `done`=0, `sign`=0, `bcd`=0; the counter, scratch and capture registers are 0.
  - Release is synchronous to the next edge.
- Latency:
  - `valid` is sampled high at edge E0.
  - `done` is high during the cycle following edge E0+2*WIDTH+1, i.e. 33 cycles for WIDTH=16.
  - `bcd` is valid from that same edge.
- `busy` is high for exactly 2*WIDTH+1 cycles per conversion and is low in IDLE, DONE and HOLD.
- Minimum spacing between conversions: 2*WIDTH+3 cycles (includes one cycle with `valid` low in HOLD).
- `valid` dropping during LOAD/ADJUST/SHIFT has no effect; the conversion completes.
- Reset mid-conversion aborts the conversion with no `done` pulse. The outputs clear to 0.

## Configuration
- `PRODUCT_SIGNED_EN` defined:
  - `product` is two's complement.
  - `sign` = MSB of the captured product.
  - `bcd` = |product|.
- `PRODUCT_SIGNED_EN` undefined:
  - `product` is unsigned.
  - `sign` is tied 0.
  - `bcd` = product.
  - The negation logic is not built.

## Test plan
- Signed build, `product`=16'h3F01 (127*127), `valid` pulse → `done` 33 cycles later; `bcd`=20'h16129, `sign`=0.
- Signed build, `product`=16'hC080 (-128*127) → `bcd`=20'h16256, `sign`=1; `product`=16'h8000 → `bcd`=20'h32768, `sign`=1.
- `product`=0 → `bcd`=0, `sign`=0; unsigned build, `product`=16'hFFFF → `bcd`=20'h65535, `sign`=0.
- `valid` held high for 100 cycles → exactly one `done` pulse. Dropping `valid` low for 1 cycle and raising it again → a second conversion with the new `product`.
- `reset` asserted at cycle 10 of a conversion:
  - Outputs go to 0 immediately; no `done` pulse.
  - Next `valid` after release → normal 33-cycle conversion.
- `product` and `valid` toggled randomly during `busy` → the result matches the value captured at E0.

Source files
------------

// File: rtl/product_bcd_converter.sv
// Sequential sign/magnitude binary-to-BCD converter (double dabble) for the Booth product word.
// Optional build macro: PRODUCT_SIGNED_EN (two's complement product; unsigned when undefined).
module product_bcd_converter #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  valid,
  input  logic [WIDTH-1:0]      product,
  output logic                  busy,
  output logic                  done,
  output logic                  sign,
  output logic [4*DIGITS-1:0]   bcd
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int BW = 4 * DIGITS;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    ADJUST,
    SHIFT,
    DONE,
    HOLD
  } state_t;

  state_t state, state_next;

  logic [WIDTH-1:0]    capture;
  logic [WIDTH-1:0]    magnitude;
  logic [BW-1:0]       scratch;
  logic [BW-1:0]       scratch_adj;
  logic [CW-1:0]       count;
  logic                sign_pend;
  logic [WIDTH-1:0]    load_mag;
  logic                load_sign;
  logic [BW+WIDTH-1:0] shifted;
  logic                last_shift;

  // Add-3 correction on every digit in parallel ahead of each shift.
  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_adjust
      assign scratch_adj[4*gi +: 4] = (scratch[4*gi +: 4] >= 4'd5) ?
                                      (scratch[4*gi +: 4] + 4'd3) :
                                      scratch[4*gi +: 4];
    end
  endgenerate

`ifdef PRODUCT_SIGNED_EN
  // Magnitude is kept WIDTH bits wide so the most negative product negates cleanly.
  assign load_sign = capture[WIDTH-1];
  assign load_mag  = load_sign ? ({WIDTH{1'b0}} - capture) : capture;
`else
  assign load_sign = 1'b0;
  assign load_mag  = capture;
`endif

  assign shifted    = {scratch, magnitude} << 1;
  assign last_shift = (count == CW'(WIDTH - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (valid) state_next = LOAD;
      end
      LOAD: begin
        busy       = 1'b1;
        state_next = ADJUST;
      end
      ADJUST: begin
        busy       = 1'b1;
        state_next = SHIFT;
      end
      SHIFT: begin
        busy       = 1'b1;
        state_next = last_shift ? DONE : ADJUST;
      end
      DONE: begin
        done       = 1'b1;
        state_next = HOLD;
      end
      HOLD: begin
        if (!valid) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      capture   <= '0;
      magnitude <= '0;
      scratch   <= '0;
      count     <= '0;
      sign_pend <= 1'b0;
      sign      <= 1'b0;
      bcd       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (valid) capture <= product;
        end
        LOAD: begin
          magnitude <= load_mag;
          sign_pend <= load_sign;
          scratch   <= '0;
          count     <= '0;
        end
        ADJUST: begin
          scratch <= scratch_adj;
        end
        SHIFT: begin
          scratch   <= shifted[BW+WIDTH-1:WIDTH];
          magnitude <= shifted[WIDTH-1:0];
          count     <= count + 1'b1;
          // Outputs take the final shifted scratch on the edge that enters DONE.
          if (last_shift) begin
            bcd  <= shifted[BW+WIDTH-1:WIDTH];
            sign <= sign_pend;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_product_bcd_converter.sv
// Directed self-checking bench for product_bcd_converter; expectations follow PRODUCT_SIGNED_EN.
module tb_product_bcd_converter;

  logic        clk;
  logic        reset;
  logic        valid;
  logic [15:0] product;
  logic        busy;
  logic        done;
  logic        sign;
  logic [19:0] bcd;

  int checks = 0;
  int errors = 0;

  product_bcd_converter #(.WIDTH(16), .DIGITS(5)) dut (
    .clk     (clk),
    .reset   (reset),
    .valid   (valid),
    .product (product),
    .busy    (busy),
    .done    (done),
    .sign    (sign),
    .bcd     (bcd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Starts a conversion and waits (bounded) for done; reports latency in edges after E0.
  task automatic convert(input logic [15:0] p, input bit scramble, output int lat, output int busy_cycles);
    @(negedge clk);
    product = p;
    valid   = 1'b1;
    @(negedge clk);
    lat = 0;
    busy_cycles = 0;
    while (!done && lat < 100) begin
      if (busy) busy_cycles++;
      if (scramble) begin
        product = 16'($urandom);
        valid   = 1'($urandom_range(0, 1));
      end else begin
        valid = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic do_conv(input string tag, input logic [15:0] p, input bit scramble,
                         input logic [19:0] exp_bcd, input logic exp_sign);
    int lat, bc;
    convert(p, scramble, lat, bc);
    check({tag, "_latency"}, lat, 33);
    check({tag, "_busy_cycles"}, bc, 33);
    check({tag, "_bcd"}, {12'd0, bcd}, {12'd0, exp_bcd});
    check({tag, "_sign"}, {31'd0, sign}, {31'd0, exp_sign});
    valid = 1'b0;
    @(negedge clk);
    check({tag, "_done_pulse_end"}, {31'd0, done}, 32'd0);
    @(negedge clk);
  endtask

  initial begin
    int dones;
    reset   = 1'b1;
    valid   = 1'b0;
    product = '0;
    #2 reset = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_sign", {31'd0, sign}, 32'd0);
    check("rst_bcd", {12'd0, bcd}, 32'd0);
    reset = 1'b1;
    @(negedge clk);

    do_conv("p3F01", 16'h3F01, 1'b0, 20'h16129, 1'b0);
`ifdef PRODUCT_SIGNED_EN
    do_conv("pC080", 16'hC080, 1'b0, 20'h16256, 1'b1);
    do_conv("p8000", 16'h8000, 1'b0, 20'h32768, 1'b1);
    do_conv("pFFFF", 16'hFFFF, 1'b0, 20'h00001, 1'b1);
`else
    do_conv("pC080", 16'hC080, 1'b0, 20'h49280, 1'b0);
    do_conv("p8000", 16'h8000, 1'b0, 20'h32768, 1'b0);
    do_conv("pFFFF", 16'hFFFF, 1'b0, 20'h65535, 1'b0);
`endif
    do_conv("p0000", 16'h0000, 1'b0, 20'h00000, 1'b0);

    // valid held high for 100 cycles must produce a single conversion
    @(negedge clk);
    product = 16'd999;
    valid   = 1'b1;
    dones   = 0;
    repeat (100) begin
      @(negedge clk);
      if (done) dones++;
    end
    check("hold_done_count", dones, 1);
    check("hold_bcd", {12'd0, bcd}, 32'h00999);
    valid = 1'b0;
    @(negedge clk);
    product = 16'd12345;
    valid   = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    dones = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) dones++;
    end
    check("retrigger_done_count", dones, 1);
    check("retrigger_bcd", {12'd0, bcd}, 32'h12345);

    // asynchronous reset in the middle of a conversion
    @(negedge clk);
    product = 16'd4321;
    valid   = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    repeat (9) @(negedge clk);
    check("mid_busy_before", {31'd0, busy}, 32'd1);
    reset = 1'b0;
    #1;
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_done", {31'd0, done}, 32'd0);
    check("mid_rst_bcd", {12'd0, bcd}, 32'd0);
    check("mid_rst_sign", {31'd0, sign}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    dones = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) dones++;
    end
    check("mid_no_done", dones, 0);
    do_conv("after_rst", 16'd4321, 1'b0, 20'h04321, 1'b0);

    // inputs scrambled while busy; result must reflect the captured word
    do_conv("scramble1", 16'd31415, 1'b1, 20'h31415, 1'b0);
    do_conv("scramble2", 16'd27182, 1'b1, 20'h27182, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
